// File: rtl/spawn_pkg.sv
// Shared constants, state type and lane-fold helper for the spawn scheduler.
package spawn_pkg;

  localparam int         NUM_SLOTS = 10;
  localparam logic [3:0] MAX_LANE  = 4'd14;
  localparam logic [3:0] LANE_FOLD = 4'd7;
  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PICK = 2'd2,
    LOAD = 2'd3
  } state_e;

  function automatic logic [3:0] map_lane(input logic [3:0] nibble);
    if (nibble == 4'd15) begin
      map_lane = LANE_FOLD;
    end else begin
      map_lane = nibble;
    end
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; exposes the folded lane index (0..14).
module spawn_lfsr
  import spawn_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] lane
);

  logic [7:0] lfsr_r;
  logic       feedback_s;

  assign feedback_s = ^(lfsr_r & LFSR_TAPS);

  // Shift register, reseeded on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[6:0], feedback_s};
    end
  end

  assign lane = map_lane(lfsr_r[3:0]);

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn sequencing FSM, interval counter, slot picker and occupancy tracking.
// Optional build macro SPAWN_NO_REPEAT_EN: never spawn twice in a row in the same lane.
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int         SPAWN_INTERVAL = 30,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] load_x,
  output logic [3:0]           rand_int,
  output logic [NUM_SLOTS-1:0] active,
  output logic                 full,
  output logic [7:0]           spawn_cnt
);

  localparam logic [7:0] INT_LAST = 8'(SPAWN_INTERVAL - 1);

  state_e               state_r;
  state_e               state_s;
  logic [7:0]           cnt_r;
  logic [NUM_SLOTS-1:0] active_r;
  logic [NUM_SLOTS-1:0] load_x_r;
  logic [3:0]           rand_int_r;
  logic [7:0]           spawn_cnt_r;
  logic [NUM_SLOTS-1:0] free_onehot_s;
  logic                 full_s;
  logic                 load_go_s;
  logic [3:0]           lane_s;
  logic [3:0]           pick_lane_s;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lane  (lane_s)
  );

  // Lowest clear bit of the registered occupancy; zero when every slot is busy
  assign free_onehot_s = ~active_r & (active_r + 10'd1);
  assign full_s        = &active_r;
  assign load_go_s     = (state_r == PICK) && (state_s == LOAD);

`ifdef SPAWN_NO_REPEAT_EN
  logic [3:0] prev_lane_r;

  // Bump a repeated lane to its neighbour, wrapping past the last lane
  always_comb begin
    pick_lane_s = lane_s;
    if (lane_s == prev_lane_r) begin
      pick_lane_s = (lane_s == MAX_LANE) ? 4'd0 : lane_s + 4'd1;
    end else begin
      pick_lane_s = lane_s;
    end
  end

  // Remember the lane of the most recent spawn
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_lane_r <= 4'd0;
    end else if (load_go_s) begin
      prev_lane_r <= pick_lane_s;
    end else begin
      prev_lane_r <= prev_lane_r;
    end
  end
`else
  assign pick_lane_s = lane_s;
`endif

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_s = WAIT;
        else        state_s = IDLE;
      end
      WAIT: begin
        if (!enable)                        state_s = IDLE;
        else if (tick && cnt_r == INT_LAST) state_s = PICK;
        else                                state_s = WAIT;
      end
      PICK: begin
        if (!enable)     state_s = IDLE;
        else if (!full_s) state_s = LOAD;
        else             state_s = PICK;
      end
      LOAD: begin
        if (enable) state_s = WAIT;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and tick interval counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        WAIT: begin
          if (!enable)                cnt_r <= 8'd0;
          else if (!tick)             cnt_r <= cnt_r;
          else if (cnt_r == INT_LAST) cnt_r <= 8'd0;
          else                        cnt_r <= cnt_r + 8'd1;
        end
        default: cnt_r <= 8'd0;
      endcase
    end
  end

  // Bank strobe, lane, occupancy and spawn counter; a set on LOAD wins over nothing since the slot was free
  always_ff @(posedge clk) begin
    if (reset) begin
      load_x_r    <= '0;
      rand_int_r  <= 4'd0;
      active_r    <= '0;
      spawn_cnt_r <= 8'd0;
    end else begin
      load_x_r    <= load_go_s ? free_onehot_s : '0;
      rand_int_r  <= load_go_s ? pick_lane_s : rand_int_r;
      active_r    <= (active_r & ~slot_done) | ((state_r == LOAD) ? load_x_r : '0);
      spawn_cnt_r <= (state_r == LOAD) ? spawn_cnt_r + 8'd1 : spawn_cnt_r;
    end
  end

  assign load_x    = load_x_r;
  assign rand_int  = rand_int_r;
  assign active    = active_r;
  assign full      = full_s;
  assign spawn_cnt = spawn_cnt_r;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Randomized plus directed bench for spawn_scheduler against a cycle-level behavioural model.
module tb_spawn_scheduler;

  localparam int         INTV = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] slot_done = 10'd0;
  logic [9:0] load_x;
  logic [3:0] rand_int;
  logic [9:0] active;
  logic       full;
  logic [7:0] spawn_cnt;

  int n_total = 0;
  int n_bad   = 0;

  spawn_scheduler #(.SPAWN_INTERVAL(INTV), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tick      (tick),
    .slot_done (slot_done),
    .load_x    (load_x),
    .rand_int  (rand_int),
    .active    (active),
    .full      (full),
    .spawn_cnt (spawn_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the scheduler is doing, in plain terms
  localparam int M_OFF = 0, M_COUNTING = 1, M_WANT_SLOT = 2, M_STROBING = 3;
  int         m_mode;
  int         m_ticks;
  logic [9:0] m_active;
  logic [9:0] m_load;
  logic [3:0] m_rand;
  logic [7:0] m_cnt;
  logic [7:0] m_lfsr;
  int         m_prev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic tk, input logic [9:0] dn);
    logic [7:0] lfsr_now;
    logic [9:0] strobe;
    int         slot;
    int         lane;
    if (r) begin
      m_mode = M_OFF; m_ticks = 0; m_active = 10'd0; m_load = 10'd0;
      m_rand = 4'd0; m_cnt = 8'd0; m_lfsr = SEED; m_prev = 0;
      return;
    end
    lfsr_now = m_lfsr;
    m_lfsr   = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    strobe   = m_load;
    m_load   = 10'd0;
    if (m_mode == M_STROBING) begin
      m_active = (m_active & ~dn) | strobe;
      m_cnt    = m_cnt + 8'd1;
      m_mode   = en ? M_COUNTING : M_OFF;
    end else if (m_mode == M_WANT_SLOT) begin
      slot = -1;
      for (int i = 9; i >= 0; i--) if (!m_active[i]) slot = i;
      m_active = m_active & ~dn;
      if (!en) begin
        m_mode = M_OFF;
      end else if (slot >= 0) begin
        lane = int'(lfsr_now) % 16;
        if (lane == 15) lane = 7;
`ifdef SPAWN_NO_REPEAT_EN
        if (lane == m_prev) lane = (lane + 1) % 15;
        m_prev = lane;
`endif
        m_load = 10'd1 << slot;
        m_rand = 4'(lane);
        m_mode = M_STROBING;
      end
    end else if (m_mode == M_COUNTING) begin
      m_active = m_active & ~dn;
      if (!en) begin
        m_mode = M_OFF; m_ticks = 0;
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == INTV) begin
          m_mode = M_WANT_SLOT; m_ticks = 0;
        end
      end
    end else begin
      m_active = m_active & ~dn;
      m_ticks  = 0;
      if (en) m_mode = M_COUNTING;
    end
  endtask

  // One clock: drive at negedge, advance model, compare all outputs at the following negedge
  task automatic cycle(input logic r, input logic en, input logic tk, input logic [9:0] dn);
    reset = r; enable = en; tick = tk; slot_done = dn;
    model_step(r, en, tk, dn);
    @(posedge clk);
    @(negedge clk);
    check_val("load_x",    32'(load_x),    32'(m_load));
    check_val("rand_int",  32'(rand_int),  32'(m_rand));
    check_val("active",    32'(active),    32'(m_active));
    check_val("full",      32'(full),      32'(&m_active));
    check_val("spawn_cnt", 32'(spawn_cnt), 32'(m_cnt));
  endtask

  task automatic tick_gap(input logic en);
    cycle(1'b0, en, 1'b1, 10'd0);
    repeat (3) cycle(1'b0, en, 1'b0, 10'd0);
  endtask

  // Full interval of ticks; strobe is visible one edge after the edge taking the last tick
  task automatic spawn_once(input logic [9:0] exp_strobe);
    tick_gap(1'b1);
    tick_gap(1'b1);
    cycle(1'b0, 1'b1, 1'b1, 10'd0);
    cycle(1'b0, 1'b1, 1'b0, 10'd0);
    check_val("strobe_walk", 32'(load_x), 32'(exp_strobe));
    cycle(1'b0, 1'b1, 1'b0, 10'd0);
  endtask

  initial begin
    int   seen_at;
    logic en_r;
    logic [9:0] dn;
    @(negedge clk);

    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    check_val("rst_load_x",   32'(load_x),    32'd0);
    check_val("rst_active",   32'(active),    32'd0);
    check_val("rst_spawn",    32'(spawn_cnt), 32'd0);
    check_val("rst_rand",     32'(rand_int),  32'd0);

    // First spawn lands in slot 0
    cycle(1'b0, 1'b1, 1'b0, 10'd0);
    spawn_once(10'h001);
    check_val("first_active", 32'(active),    32'h001);
    check_val("first_cnt",    32'(spawn_cnt), 32'd1);

    // Fill the bank, then stall while full
    for (int s = 1; s < 10; s++) spawn_once(10'd1 << s);
    check_val("full_active", 32'(active), 32'h3FF);
    check_val("full_flag",   32'(full),   32'd1);
    repeat (3) tick_gap(1'b1);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 10'd0);
    cycle(1'b0, 1'b1, 1'b0, 10'h010);
    cycle(1'b0, 1'b1, 1'b0, 10'd0);
    check_val("refill_slot4", 32'(load_x), 32'h010);
    cycle(1'b0, 1'b1, 1'b0, 10'd0);

    // Free slot 5, then retire slot 2 during the LOAD of slot 5
    cycle(1'b0, 1'b1, 1'b0, 10'h020);
    tick_gap(1'b1);
    tick_gap(1'b1);
    cycle(1'b0, 1'b1, 1'b1, 10'd0);
    cycle(1'b0, 1'b1, 1'b0, 10'd0);
    check_val("load_slot5", 32'(load_x), 32'h020);
    cycle(1'b0, 1'b1, 1'b0, 10'h004);
    check_val("swap_active", 32'(active), 32'h3FB);

    // Pause mid-interval for 100 ticks, then a fresh interval is needed
    tick_gap(1'b1);
    repeat (100) tick_gap(1'b0);
    check_val("pause_active", 32'(active), 32'h3FB);
    cycle(1'b0, 1'b1, 1'b0, 10'd0);
    seen_at = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 10'd0);
      for (int j = 0; j < 3; j++) begin
        cycle(1'b0, 1'b1, 1'b0, 10'd0);
        if (load_x != 10'd0 && seen_at == 0) seen_at = k;
      end
    end
    check_val("resume_ticks", 32'(seen_at), 32'd3);

    // Reset in the middle of a LOAD
    cycle(1'b0, 1'b1, 1'b0, 10'h080);
    seen_at = 0;
    for (int i = 0; i < 60 && seen_at == 0; i++) begin
      cycle(1'b0, 1'b1, (i % 4) == 0, 10'd0);
      if (load_x != 10'd0) seen_at = 1;
    end
    check_val("wait_load", 32'(seen_at), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 10'd0);
    check_val("mid_rst_load",   32'(load_x),          32'd0);
    check_val("mid_rst_active", 32'(active),          32'd0);
    check_val("mid_rst_cnt",    32'(spawn_cnt),       32'd0);
    check_val("mid_rst_lfsr",   32'(dut.u_lfsr.lfsr_r), 32'(SEED));

    // Randomized traffic
    en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      dn = ($urandom_range(0, 5) == 0) ? (10'd1 << $urandom_range(0, 9)) : 10'd0;
      cycle($urandom_range(0, 1499) == 0, en_r, $urandom_range(0, 3) == 0, dn);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
